// File: rtl/video_copper.sv
// Raster-synchronised register-write sequencer: replays a CPU-loaded command list every frame
// onto the video IO register port, yielding to the CPU whenever it is using the port.
module video_copper #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            cpu_io_addr,
  input  logic [7:0]            cpu_io_wrdata,
  input  logic                  cpu_io_wren,
  input  logic                  cpu_io_rden,
  input  logic [DEPTH_LOG2-1:0] lst_addr,
  input  logic [20:0]           lst_wrdata,
  input  logic                  lst_wren,
  input  logic                  enable,
  input  logic [7:0]            vpos,
  input  logic                  vblank,
  output logic [3:0]            io_addr,
  output logic [7:0]            io_wrdata,
  output logic                  io_wren,
  output logic                  busy,
  output logic [DEPTH_LOG2-1:0] cur_idx
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LastIdx = DEPTH_LOG2'(Depth - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StWrite,
    StDone
  } state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] line;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t                  list_mem [Depth];
  cmd_t                  cmd_q;
  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  vblank_q;
  logic                  busy_q, busy_d;
  logic [DEPTH_LOG2-1:0] cur_idx_q;

  logic cpu_claim;
  logic restart;
  logic grant;

  // List RAM with registered read; the read port is only sampled while fetching, so an
  // entry already captured in cmd_q is unaffected by later list writes.
  always_ff @(posedge clk) begin
    if (lst_wren) begin
      list_mem[lst_addr] <= cmd_t'(lst_wrdata);
    end
    if (state_q == StFetch) begin
      cmd_q <= list_mem[idx_q];
    end
  end

  assign cpu_claim = cpu_io_wren | cpu_io_rden;
  assign restart   = enable & vblank & ~vblank_q;
  // A restart or disable in the same cycle drops the pending write.
  assign grant     = (state_q == StWrite) & ~cpu_claim & enable & ~restart;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = StIdle;
      idx_d   = '0;
    end else if (restart) begin
      state_d = StFetch;
      idx_d   = '0;
    end else begin
      case (state_q)
        StFetch: state_d = StWait;
        StWait: begin
          if (cmd_q.last) begin
            state_d = StDone;
          end else if (vpos == cmd_q.line) begin
            state_d = StWrite;
          end
        end
        StWrite: begin
          if (grant) begin
            if (idx_q == LastIdx) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StFetch;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == StFetch) | (state_d == StWait) | (state_d == StWrite);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      vblank_q  <= 1'b0;
      busy_q    <= 1'b0;
      cur_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vblank_q  <= vblank;
      busy_q    <= busy_d;
      cur_idx_q <= idx_d;
    end
  end

  always_comb begin
    io_addr   = cpu_io_addr;
    io_wrdata = cpu_io_wrdata;
    io_wren   = cpu_io_wren;
    if (grant) begin
      io_addr   = cmd_q.addr;
      io_wrdata = cmd_q.data;
      io_wren   = 1'b1;
    end
  end

  assign busy    = busy_q;
  assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_video_copper.sv
// Directed self-checking bench for video_copper; a negedge monitor logs copper-issued writes.
module tb_video_copper;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] cpu_io_addr;
  logic [7:0] cpu_io_wrdata;
  logic       cpu_io_wren;
  logic       cpu_io_rden;
  logic [5:0] lst_addr;
  logic [20:0] lst_wrdata;
  logic       lst_wren;
  logic       enable;
  logic [7:0] vpos;
  logic       vblank;
  logic [3:0] io_addr;
  logic [7:0] io_wrdata;
  logic       io_wren;
  logic       busy;
  logic [5:0] cur_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0] m_addr [128];
  logic [7:0] m_data [128];
  logic [7:0] m_vpos [128];
  int         m_cyc  [128];
  int         m_n = 0;

  video_copper #(.DEPTH_LOG2(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_io_addr  (cpu_io_addr),
    .cpu_io_wrdata(cpu_io_wrdata),
    .cpu_io_wren  (cpu_io_wren),
    .cpu_io_rden  (cpu_io_rden),
    .lst_addr     (lst_addr),
    .lst_wrdata   (lst_wrdata),
    .lst_wren     (lst_wren),
    .enable       (enable),
    .vpos         (vpos),
    .vblank       (vblank),
    .io_addr      (io_addr),
    .io_wrdata    (io_wrdata),
    .io_wren      (io_wren),
    .busy         (busy),
    .cur_idx      (cur_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Any write seen while the CPU is not using the port must come from the copper.
  always @(negedge clk) begin
    if (reset_n && io_wren && !cpu_io_wren && !cpu_io_rden) begin
      if (m_n < 128) begin
        m_addr[m_n] <= io_addr;
        m_data[m_n] <= io_wrdata;
        m_vpos[m_n] <= vpos;
        m_cyc[m_n]  <= cyc;
      end
      m_n <= m_n + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int i, input logic e, input logic [7:0] l, input logic [3:0] a,
                      input logic [7:0] d);
    lst_addr   = 6'(i);
    lst_wrdata = {e, l, a, d};
    lst_wren   = 1'b1;
    step(1);
    lst_wren   = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (busy !== 1'b0 || cur_idx !== 6'd0 || io_wren !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b cur_idx=%0d io_wren=%b want 0/0/0", busy, cur_idx,
               io_wren);
    end
    cpu_io_addr = 4'd3; cpu_io_wrdata = 8'h55; cpu_io_wren = 1'b1;
    #1;
    checks++;
    if (io_addr !== 4'd3 || io_wrdata !== 8'h55 || io_wren !== 1'b1) begin
      failures++;
      $display("FAIL reset_passthru: got %0h/%0h/%b want 3/55/1", io_addr, io_wrdata, io_wren);
    end
    cpu_io_wren = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    int base, c0;
    load(0, 1'b0, 8'd20, 4'd3, 8'h10);
    load(1, 1'b0, 8'd20, 4'd1, 8'h22);
    load(2, 1'b1, 8'd0, 4'd0, 8'h00);
    enable = 1'b1;
    vpos = 8'd0;
    base = m_n;
    pulse_vblank();
    step(3);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    vpos = 8'd19;
    step(2);
    c0 = cyc;
    vpos = 8'd20;
    step(12);
    checks++;
    if (m_n - base !== 2) begin
      failures++;
      $display("FAIL basic_count: got %0d want 2", m_n - base);
    end
    checks++;
    if (m_addr[base] !== 4'd3 || m_data[base] !== 8'h10 || m_cyc[base] !== c0 + 1) begin
      failures++;
      $display("FAIL basic_w0: got %0h/%0h @%0d want 3/10 @%0d", m_addr[base], m_data[base],
               m_cyc[base], c0 + 1);
    end
    checks++;
    if (m_addr[base+1] !== 4'd1 || m_data[base+1] !== 8'h22 || m_cyc[base+1] !== c0 + 4) begin
      failures++;
      $display("FAIL basic_w1: got %0h/%0h @%0d want 1/22 @%0d", m_addr[base+1],
               m_data[base+1], m_cyc[base+1], c0 + 4);
    end
    checks++;
    if (busy !== 1'b0 || cur_idx !== 6'd2) begin
      failures++;
      $display("FAIL basic_done: busy=%b cur_idx=%0d want 0/2", busy, cur_idx);
    end
    vpos = 8'd21;
    step(4);
    vpos = 8'd20;
    step(6);
    checks++;
    if (m_n - base !== 2) begin
      failures++;
      $display("FAIL basic_nomore: got %0d writes want 2", m_n - base);
    end
  endtask

  task automatic test_contention();
    int base, c0;
    vpos = 8'd0;
    base = m_n;
    pulse_vblank();
    step(4);
    c0 = cyc;
    vpos = 8'd20;
    cpu_io_addr = 4'd5; cpu_io_wrdata = 8'hAA; cpu_io_wren = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (io_addr !== 4'd5 || io_wrdata !== 8'hAA || io_wren !== 1'b1) begin
        failures++;
        $display("FAIL cont_cpu%0d: got %0h/%0h/%b want 5/aa/1", i, io_addr, io_wrdata, io_wren);
      end
      step(1);
    end
    cpu_io_wren = 1'b0;
    step(10);
    checks++;
    if (m_n - base !== 2) begin
      failures++;
      $display("FAIL cont_count: got %0d want 2", m_n - base);
    end
    checks++;
    if (m_addr[base] !== 4'd3 || m_data[base] !== 8'h10 || m_cyc[base] !== c0 + 5) begin
      failures++;
      $display("FAIL cont_w0: got %0h/%0h @%0d want 3/10 @%0d", m_addr[base], m_data[base],
               m_cyc[base], c0 + 5);
    end
    checks++;
    if (m_addr[base+1] !== 4'd1 || m_data[base+1] !== 8'h22 || m_cyc[base+1] !== c0 + 8) begin
      failures++;
      $display("FAIL cont_w1: got %0h/%0h @%0d want 1/22 @%0d", m_addr[base+1],
               m_data[base+1], m_cyc[base+1], c0 + 8);
    end
  endtask

  task automatic test_full64();
    int base;
    for (int k = 0; k < 64; k++) load(k, 1'b0, 8'(10 + k), 4'(k), 8'(k));
    vpos = 8'd9;
    base = m_n;
    pulse_vblank();
    for (int l = 9; l < 76; l++) begin
      vpos = 8'(l);
      step(4);
    end
    checks++;
    if (m_n - base !== 64) begin
      failures++;
      $display("FAIL full_count: got %0d want 64", m_n - base);
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (m_addr[base+k] !== 4'(k) || m_data[base+k] !== 8'(k) ||
          m_vpos[base+k] !== 8'(10 + k)) begin
        failures++;
        $display("FAIL full_w%0d: got %0h/%0h line %0d want %0h/%0h line %0d", k,
                 m_addr[base+k], m_data[base+k], m_vpos[base+k], k % 16, k, 10 + k);
      end
    end
    checks++;
    if (busy !== 1'b0 || cur_idx !== 6'd63) begin
      failures++;
      $display("FAIL full_done: busy=%b cur_idx=%0d want 0/63", busy, cur_idx);
    end
    for (int l = 10; l < 16; l++) begin
      vpos = 8'(l);
      step(4);
    end
    checks++;
    if (m_n - base !== 64 || cur_idx !== 6'd63) begin
      failures++;
      $display("FAIL full_nowrap: writes=%0d cur_idx=%0d want 64/63", m_n - base, cur_idx);
    end
  endtask

  task automatic test_enable();
    int base;
    load(0, 1'b0, 8'd100, 4'd2, 8'h33);
    load(1, 1'b0, 8'd101, 4'd4, 8'h44);
    load(2, 1'b1, 8'd0, 4'd0, 8'h00);
    vpos = 8'd99;
    base = m_n;
    pulse_vblank();
    step(4);
    checks++;
    if (busy !== 1'b1 || cur_idx !== 6'd0) begin
      failures++;
      $display("FAIL en_wait: busy=%b cur_idx=%0d want 1/0", busy, cur_idx);
    end
    enable = 1'b0;
    vpos = 8'd100;
    step(1);
    checks++;
    if (busy !== 1'b0 || cur_idx !== 6'd0) begin
      failures++;
      $display("FAIL en_off: busy=%b cur_idx=%0d want 0/0", busy, cur_idx);
    end
    step(5);
    enable = 1'b1;
    step(5);
    vpos = 8'd101;
    step(3);
    checks++;
    if (m_n - base !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL en_idle: writes=%0d busy=%b want 0/0", m_n - base, busy);
    end
    vpos = 8'd99;
    pulse_vblank();
    step(3);
    vpos = 8'd100;
    step(4);
    vpos = 8'd101;
    step(4);
    checks++;
    if (m_n - base !== 2) begin
      failures++;
      $display("FAIL en_replay_count: got %0d want 2", m_n - base);
    end
    checks++;
    if (m_addr[base] !== 4'd2 || m_data[base] !== 8'h33 ||
        m_addr[base+1] !== 4'd4 || m_data[base+1] !== 8'h44) begin
      failures++;
      $display("FAIL en_replay: got %0h/%0h %0h/%0h want 2/33 4/44", m_addr[base], m_data[base],
               m_addr[base+1], m_data[base+1]);
    end
  endtask

  task automatic test_restart();
    int base;
    load(0, 1'b0, 8'd30, 4'd8, 8'h88);
    load(1, 1'b0, 8'd250, 4'd6, 8'h66);
    load(2, 1'b1, 8'd0, 4'd0, 8'h00);
    vpos = 8'd29;
    base = m_n;
    pulse_vblank();
    step(3);
    vpos = 8'd30;
    step(4);
    vpos = 8'd40;
    step(4);
    checks++;
    if (busy !== 1'b1 || cur_idx !== 6'd1) begin
      failures++;
      $display("FAIL rs_pending: busy=%b cur_idx=%0d want 1/1", busy, cur_idx);
    end
    vblank = 1'b1;
    step(1);
    checks++;
    if (busy !== 1'b1 || cur_idx !== 6'd0) begin
      failures++;
      $display("FAIL rs_restart: busy=%b cur_idx=%0d want 1/0", busy, cur_idx);
    end
    vblank = 1'b0;
    step(3);
    vpos = 8'd250;
    step(5);
    vpos = 8'd30;
    step(5);
    vpos = 8'd250;
    step(5);
    checks++;
    if (m_n - base !== 3) begin
      failures++;
      $display("FAIL rs_count: got %0d want 3", m_n - base);
    end
    checks++;
    if (m_data[base] !== 8'h88 || m_data[base+1] !== 8'h88 || m_data[base+2] !== 8'h66 ||
        m_addr[base+1] !== 4'd8 || m_addr[base+2] !== 4'd6) begin
      failures++;
      $display("FAIL rs_order: got %0h %0h %0h want 88 88 66", m_data[base], m_data[base+1],
               m_data[base+2]);
    end
  endtask

  task automatic test_async_reset();
    vpos = 8'd29;
    pulse_vblank();
    step(3);
    cpu_io_rden = 1'b1;
    cpu_io_addr = 4'd9;
    vpos = 8'd30;
    step(3);
    checks++;
    if (busy !== 1'b1 || io_wren !== 1'b0) begin
      failures++;
      $display("FAIL ar_held: busy=%b io_wren=%b want 1/0", busy, io_wren);
    end
    #2;
    cpu_io_rden = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (io_wren !== 1'b0 || busy !== 1'b0 || cur_idx !== 6'd0) begin
      failures++;
      $display("FAIL ar_clear: io_wren=%b busy=%b cur_idx=%0d want 0/0/0", io_wren, busy,
               cur_idx);
    end
    cpu_io_addr = 4'd3; cpu_io_wrdata = 8'h55; cpu_io_wren = 1'b1;
    #1;
    checks++;
    if (io_addr !== 4'd3 || io_wrdata !== 8'h55 || io_wren !== 1'b1) begin
      failures++;
      $display("FAIL ar_passthru: got %0h/%0h/%b want 3/55/1", io_addr, io_wrdata, io_wren);
    end
    step(1);
    cpu_io_wren = 1'b0;
    reset_n = 1'b1;
    step(2);
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_io_addr = '0; cpu_io_wrdata = '0; cpu_io_wren = 1'b0; cpu_io_rden = 1'b0;
    lst_addr = '0; lst_wrdata = '0; lst_wren = 1'b0;
    enable = 1'b0; vpos = '0; vblank = 1'b0;
    test_reset();
    test_basic();
    test_contention();
    test_full64();
    test_enable();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
